// File: rtl/cuckoo_match_collect.sv
// Collects per-byte pattern-table compare hits, buffers them per result cycle, and
// serialises them into one match record per handshake with payload offset and index.
module cuckoo_match_collect #(
    parameter int DEPTH   = 8,
    parameter int IDX_DLY = 2,
    parameter int OFF_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic             sop,
    input  logic [1:0]       compare_out,
    input  logic [1:0]       compare_out_nocase,
    input  logic [1:0]       suffix,
    input  logic [1:0]       suffix_nocase,
    input  logic [8:0]       idx_a,
    input  logic [8:0]       idx_b,
    input  logic [8:0]       idx_a_nocase,
    input  logic [8:0]       idx_b_nocase,
    input  logic             clear_ovf,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_nocase,
    output logic             m_port,
    output logic             m_suffix,
    output logic [8:0]       m_idx,
    output logic [OFF_W-1:0] m_offset,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic             dbg_state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 4 + 4 + 36 + OFF_W;
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    // Slot order everywhere: 0 = case A, 1 = case B, 2 = nocase A, 3 = nocase B.
    logic [3:0]       w_hits;
    logic [3:0]       w_sufs;
    logic [3:0][8:0]  w_idx_in;
    logic [3:0][8:0]  w_idx_d;
    logic [OFF_W-1:0] w_tag_off;
    logic             w_any_hit, w_full, w_empty, w_push, w_drop, w_pop, w_ack;
    logic [REC_W-1:0] w_rec_in, w_head;
    logic [1:0]       w_sel;
    logic [3:0]       w_mask_clr;
    logic             w_valid;
    state_t           w_state_nxt;

    logic [OFF_W-1:0] r_off_cnt;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [7:0]       r_drop;
    state_t           r_state;
    logic [3:0]       r_mask;
    logic [3:0]       r_w_suf;
    logic [3:0][8:0]  r_w_idx;
    logic [OFF_W-1:0] r_w_off;

    assign w_hits    = {compare_out_nocase, compare_out};
    assign w_sufs    = {suffix_nocase, suffix};
    assign w_idx_in  = {idx_b_nocase, idx_a_nocase, idx_b, idx_a};
    assign w_tag_off = sop ? '0 : r_off_cnt;
    assign w_any_hit = res_valid & (|w_hits);
    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = w_any_hit & ~w_full;
    assign w_drop    = w_any_hit & w_full;
    assign w_rec_in  = {w_hits, w_sufs, w_idx_d, w_tag_off};
    assign w_head    = r_mem[r_rd_ptr];

    // Index delay lines run every cycle so indices line up with the compare pipeline.
    generate
        if (IDX_DLY == 0) begin : g_no_dly
            assign w_idx_d = w_idx_in;
        end else begin : g_dly
            logic [3:0][8:0] r_pipe [IDX_DLY];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < IDX_DLY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_idx_in;
                    for (int i = 1; i < IDX_DLY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_idx_d = r_pipe[IDX_DLY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off_cnt <= '0;
        end else if (res_valid) begin
            if (sop)                 r_off_cnt <= OFF_ONE;
            else if (r_off_cnt != '1) r_off_cnt <= r_off_cnt + OFF_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rec_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf leaves exactly one drop recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf  <= 1'b1;
            r_drop <= clear_ovf ? 8'd1 : ((r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop);
        end else if (clear_ovf) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

    always_comb begin
        w_sel = 2'd0;
        if      (r_mask[0]) w_sel = 2'd0;
        else if (r_mask[1]) w_sel = 2'd1;
        else if (r_mask[2]) w_sel = 2'd2;
        else if (r_mask[3]) w_sel = 2'd3;
    end
    assign w_mask_clr = r_mask & ~(4'b0001 << w_sel);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (m_ready) begin
                    w_ack = 1'b1;
                    if (w_mask_clr == '0) begin
                        if (!w_empty) w_pop       = 1'b1;
                        else          w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_w_suf <= '0;
            r_w_idx <= '0;
            r_w_off <= '0;
        end else if (w_pop) begin
            {r_mask, r_w_suf, r_w_idx, r_w_off} <= w_head;
        end else if (w_ack) begin
            r_mask <= w_mask_clr;
        end
    end

    always_comb begin
        w_valid   = (r_state == S_EMIT) & ~rst;
        m_valid   = w_valid;
        m_nocase  = w_valid & w_sel[1];
        m_port    = w_valid & w_sel[0];
        m_suffix  = w_valid & r_w_suf[w_sel];
        m_idx     = w_valid ? r_w_idx[w_sel] : '0;
        m_offset  = w_valid ? r_w_off : '0;
        overflow  = r_ovf & ~rst;
        drop_cnt  = rst ? '0 : r_drop;
        dbg_state = r_state;
    end
endmodule

// File: tb/tb_cuckoo_match_collect.sv
// Directed bench for cuckoo_match_collect: latency, hit ordering, offsets, overflow,
// backpressure and reset behaviour, each checked against hand-computed values.
module tb_cuckoo_match_collect;
    logic        clk, rst, res_valid, sop, clear_ovf, m_ready;
    logic [1:0]  compare_out, compare_out_nocase, suffix, suffix_nocase;
    logic [8:0]  idx_a, idx_b, idx_a_nocase, idx_b_nocase;
    logic        m_valid, m_nocase, m_port, m_suffix, overflow, dbg_state;
    logic [8:0]  m_idx;
    logic [10:0] m_offset;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc, first_k, last_k;

    logic       e_nc  [3] = '{1'b0, 1'b0, 1'b1};
    logic       e_pt  [3] = '{1'b0, 1'b1, 1'b0};
    logic       e_sf  [3] = '{1'b1, 1'b1, 1'b0};
    logic [8:0] e_idx [3] = '{9'h101, 9'h102, 9'h103};

    cuckoo_match_collect dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .sop(sop),
        .compare_out(compare_out), .compare_out_nocase(compare_out_nocase),
        .suffix(suffix), .suffix_nocase(suffix_nocase),
        .idx_a(idx_a), .idx_b(idx_b), .idx_a_nocase(idx_a_nocase), .idx_b_nocase(idx_b_nocase),
        .clear_ovf(clear_ovf), .m_valid(m_valid), .m_ready(m_ready),
        .m_nocase(m_nocase), .m_port(m_port), .m_suffix(m_suffix),
        .m_idx(m_idx), .m_offset(m_offset), .overflow(overflow),
        .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        res_valid = 0; sop = 0; clear_ovf = 0;
        compare_out = 0; compare_out_nocase = 0; suffix = 0; suffix_nocase = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic nc, input logic pt, input logic sf,
                           input logic [8:0] ix, input logic [10:0] off);
        chk({tag, "_valid"},  m_valid,  1);
        chk({tag, "_nocase"}, m_nocase, nc);
        chk({tag, "_port"},   m_port,   pt);
        chk({tag, "_suffix"}, m_suffix, sf);
        chk({tag, "_idx"},    m_idx,    ix);
        chk({tag, "_offset"}, m_offset, off);
    endtask

    initial begin
        rst = 1; m_ready = 0; clr_in();
        idx_a = 0; idx_b = 0; idx_a_nocase = 0; idx_b_nocase = 0;
        tick(); tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_idx", m_idx, 0);
        chk("rst_offset", m_offset, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_state", dbg_state, 0);
        rst = 0;

        // single case-A hit, index two cycles ahead
        idx_a = 9'h05A; tick();
        idx_a = 9'h000; tick();
        res_valid = 1; sop = 1; compare_out = 2'b01; suffix = 2'b01; m_ready = 1;
        chk("lat_t0_valid", m_valid, 0);
        tick(); clr_in();
        chk("lat_t1_valid", m_valid, 0);
        tick();
        chk_rec("lat_t2", 0, 0, 1, 9'h05A, 0);
        tick();
        chk("lat_t3_valid", m_valid, 0);

        // four hits in one cycle, emitted in fixed order
        idx_a = 9'h101; idx_b = 9'h102; idx_a_nocase = 9'h103; idx_b_nocase = 9'h104;
        tick(); tick();
        res_valid = 1; sop = 0; compare_out = 2'b11; compare_out_nocase = 2'b11;
        suffix = 2'b10; suffix_nocase = 2'b01;
        tick(); clr_in();
        chk("quad_t1_valid", m_valid, 0);
        tick(); chk_rec("quad0", 0, 0, 0, 9'h101, 1);
        tick(); chk_rec("quad1", 0, 1, 1, 9'h102, 1);
        tick(); chk_rec("quad2", 1, 0, 1, 9'h103, 1);
        tick(); chk_rec("quad3", 1, 1, 0, 9'h104, 1);
        tick(); chk("quad_end_valid", m_valid, 0);

        // offset counting: sop byte, four plain bytes, a gap, then a hit at offset 5
        res_valid = 1; sop = 1; tick();
        sop = 0; repeat (4) tick();
        res_valid = 0; tick();
        res_valid = 1; compare_out_nocase = 2'b10; suffix_nocase = 2'b10;
        tick(); clr_in();
        chk("off5_t1_valid", m_valid, 0);
        tick(); chk_rec("off5", 1, 1, 1, 9'h104, 5);
        tick();
        chk("off_sop_pre_valid", m_valid, 0);
        res_valid = 1; sop = 1; compare_out = 2'b10; suffix = 2'b00;
        tick(); clr_in();
        tick(); chk_rec("off_sop", 0, 1, 0, 9'h102, 0);
        tick(); chk("off_sop_end_valid", m_valid, 0);

        // overflow: ten hits with the consumer stalled
        m_ready = 0;
        for (int k = 0; k < 10; k++) begin
            res_valid = 1; sop = (k == 0); compare_out = 2'b01; suffix = 2'b00;
            tick();
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 1);
        chk("ovf_stall_valid", m_valid, 1);
        chk("ovf_stall_offset", m_offset, 0);
        res_valid = 1; sop = 0; compare_out = 2'b01; clear_ovf = 1;
        tick(); clr_in();
        chk("ovf_drop_wins_flag", overflow, 1);
        chk("ovf_drop_wins_cnt", drop_cnt, 1);
        clear_ovf = 1;
        tick(); clear_ovf = 0;
        chk("ovf_clear_flag", overflow, 0);
        chk("ovf_clear_cnt", drop_cnt, 0);
        chk("ovf_hold_offset", m_offset, 0);
        m_ready = 1; n_acc = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                chk("ovf_drain_offset", m_offset, n_acc);
                if (first_k < 0) first_k = k;
                last_k = k;
                n_acc++;
            end
            tick();
        end
        chk("ovf_accepted", n_acc, 9);
        chk("ovf_no_bubble", last_k - first_k, 8);
        chk("ovf_drain_end_valid", m_valid, 0);

        // three-hit record under toggling ready
        m_ready = 0;
        res_valid = 1; sop = 0; compare_out = 2'b11; compare_out_nocase = 2'b01;
        suffix = 2'b11; suffix_nocase = 2'b00;
        tick(); clr_in();
        chk("bp_t1_valid", m_valid, 0);
        tick();
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            m_ready = (k % 2 == 1);
            if (m_valid) begin
                if (n_acc < 3) chk_rec("bp_rec", e_nc[n_acc], e_pt[n_acc], e_sf[n_acc], e_idx[n_acc], 11);
                else           chk("bp_extra_valid", m_valid, 0);
                if (m_ready) n_acc++;
            end
            tick();
        end
        chk("bp_handshakes", n_acc, 3);
        chk("bp_end_valid", m_valid, 0);

        // reset while emitting with two records still buffered
        m_ready = 0;
        for (int k = 0; k < 3; k++) begin
            res_valid = 1; sop = (k == 0); compare_out = 2'b01; suffix = 2'b00;
            tick();
        end
        chk("mrst_pre_valid", m_valid, 1);
        chk("mrst_pre_offset", m_offset, 0);
        rst = 1; res_valid = 1; sop = 0; compare_out = 2'b11;
        #1;
        chk("mrst_in_rst_valid", m_valid, 0);
        chk("mrst_in_rst_offset", m_offset, 0);
        tick();
        rst = 0; clr_in(); m_ready = 1;
        chk("mrst_after_valid", m_valid, 0);
        chk("mrst_after_state", dbg_state, 0);
        res_valid = 1; sop = 0; compare_out = 2'b01; suffix = 2'b01;
        tick();
        suffix = 2'b00;
        chk("mrst_c5_valid", m_valid, 0);
        tick(); clr_in();
        chk_rec("mrst_first", 0, 0, 1, 9'h000, 0);
        tick(); chk_rec("mrst_second", 0, 0, 0, 9'h000, 1);
        tick(); chk("mrst_flushed_valid", m_valid, 0);
        res_valid = 1; sop = 1; compare_out = 2'b01;
        tick(); clr_in();
        tick(); chk_rec("mrst_sop", 0, 0, 0, 9'h101, 0);
        tick(); chk("mrst_end_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
